hub75_bcm_scan: RTL and testbench

Parametrised HUB75 scan engine with binary-coded modulation (BCM) and global brightness. It replaces the fixed single-plane display stage between the frame buffer (or test-pattern source) and the panel pins. It generalises segment count, row count and colour depth. It overlaps shifting of the next bitplane with display of the current one, so the panel is blanked only during latch.

---
 rtl/hub75_pkg.sv | 19 +
 rtl/hub75_clk_div.sv | 31 +++
 rtl/hub75_bcm_scan.sv | 199 +++++++++++++++++++
 tb/tb_hub75_bcm_scan.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// Shared types and sizing helpers for the HUB75 BCM scan engine.
package hub75_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_WAIT,
    S_LATCH
  } scan_state_t;

  typedef logic [2:0] rgb_lane_t;

  // Wide enough for brightness * lsb_time shifted by the top bitplane index.
  function automatic int disp_cnt_width(input int bpp, input int lsb_time);
    return 8 + $clog2(lsb_time + 1) + bpp;
  endfunction

endpackage

// File: rtl/hub75_clk_div.sv
// Pixel tick generator: one-cycle tick every i_clk_div+1 clocks while enabled.
module hub75_clk_div
  import hub75_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_enable,
  input  logic [3:0] i_clk_div,
  output logic       tick
);

  logic [3:0] cnt;

  // Compare with >= so a lowered divider takes effect without wrapping through 15.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (!i_enable) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt >= i_clk_div) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/hub75_bcm_scan.sv
// HUB75 scan engine with binary-coded modulation and global brightness; the
// next bitplane is shifted while the current one is still being displayed.
module hub75_bcm_scan
  import hub75_pkg::*;
#(
  parameter int  hpixel_p   = 64,
  parameter int  vpixel_p   = 64,
  parameter int  bpp_p      = 8,
  parameter int  segments_p = 2,
  parameter int  lsb_time_p = 1,
  localparam int rows_p     = vpixel_p / segments_p,
  localparam int row_bits_p = $clog2(rows_p),
  localparam int addr_w     = $clog2(hpixel_p * vpixel_p)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_enable,
  input  logic [3:0]                    i_clk_div,
  input  logic [7:0]                    i_brightness,
  output logic [addr_w-1:0]             o_rd_addr,
  input  logic [segments_p*3*bpp_p-1:0] i_rd_data,
  output logic                          o_clk,
  output logic                          o_stb,
  output logic                          o_oe,
  output logic [row_bits_p-1:0]         o_row,
  output logic [segments_p*3-1:0]       o_rgb,
  output logic                          o_frame_done
);

  localparam int col_w   = (hpixel_p > 1) ? $clog2(hpixel_p) : 1;
  localparam int plane_w = (bpp_p > 1) ? $clog2(bpp_p) : 1;
  localparam int disp_w  = disp_cnt_width(bpp_p, lsb_time_p);

  localparam logic [col_w-1:0]      col_last   = col_w'(hpixel_p - 1);
  localparam logic [plane_w-1:0]    plane_last = plane_w'(bpp_p - 1);
  localparam logic [row_bits_p-1:0] row_last   = row_bits_p'(rows_p - 1);

  scan_state_t state, state_nxt;

  logic                          tick;
  logic                          phase;
  logic                          lat_phase;
  logic [col_w-1:0]              col;
  logic [row_bits_p-1:0]         row;
  logic [row_bits_p-1:0]         row_nxt;
  logic [plane_w-1:0]            plane;
  logic [disp_w-1:0]             disp;
  logic [disp_w-1:0]             disp_load;
  logic [addr_w-1:0]             row_base;
  logic                          do_phase_a;
  logic                          do_phase_b;
  logic                          do_latch_1;
  logic                          do_latch_2;
  logic [bpp_p-1:0]              chan;
  rgb_lane_t [segments_p-1:0]    shift_bits;

  hub75_clk_div u_clk_div (
    .clk       (clk),
    .rst       (rst),
    .i_enable  (i_enable),
    .i_clk_div (i_clk_div),
    .tick      (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    do_phase_a = 1'b0;
    do_phase_b = 1'b0;
    do_latch_1 = 1'b0;
    do_latch_2 = 1'b0;
    if (!i_enable) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  state_nxt = S_LOAD;
        S_LOAD:  if (tick) state_nxt = S_SHIFT;
        S_SHIFT: begin
          if (tick) begin
            if (!phase) begin
              do_phase_a = 1'b1;
            end else begin
              do_phase_b = 1'b1;
              if (col == col_last) state_nxt = S_WAIT;
            end
          end
        end
        S_WAIT:  if (disp == '0) state_nxt = S_LATCH;
        S_LATCH: begin
          if (tick) begin
            if (!lat_phase) begin
              do_latch_1 = 1'b1;
            end else begin
              do_latch_2 = 1'b1;
              state_nxt  = S_LOAD;
            end
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Lane word per segment is {R,G,B}, each bpp_p wide; pick bit `plane` of each.
  always_comb begin
    chan       = '0;
    shift_bits = '0;
    for (int s = 0; s < segments_p; s++) begin
      for (int c = 0; c < 3; c++) begin
        chan             = i_rd_data[(s*3 + c)*bpp_p +: bpp_p];
        shift_bits[s][c] = chan[plane];
      end
    end
  end

  always_comb begin
    row_nxt = row;
    if (plane == plane_last) row_nxt = (row == row_last) ? '0 : row + 1'b1;
    row_base  = addr_w'(row_nxt) * addr_w'(hpixel_p);
    disp_load = (disp_w'(i_brightness) * disp_w'(lsb_time_p)) << plane;
  end

  // The read address runs one column ahead: it advances at phase A, after the
  // current column has been captured, so the frame buffer has a full tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_clk        <= 1'b0;
      o_stb        <= 1'b0;
      o_oe         <= 1'b1;
      o_row        <= '0;
      o_rgb        <= '0;
      o_rd_addr    <= '0;
      o_frame_done <= 1'b0;
      phase        <= 1'b0;
      lat_phase    <= 1'b0;
      col          <= '0;
      row          <= '0;
      plane        <= '0;
      disp         <= '0;
    end else if (!i_enable) begin
      o_clk        <= 1'b0;
      o_stb        <= 1'b0;
      o_oe         <= 1'b1;
      o_row        <= '0;
      o_rgb        <= '0;
      o_rd_addr    <= '0;
      o_frame_done <= 1'b0;
      phase        <= 1'b0;
      lat_phase    <= 1'b0;
      col          <= '0;
      row          <= '0;
      plane        <= '0;
      disp         <= '0;
    end else begin
      o_frame_done <= 1'b0;
      if (disp != '0) begin
        disp <= disp - 1'b1;
        if (disp == disp_w'(1)) o_oe <= 1'b1;
      end
      if (do_phase_a) begin
        o_clk <= 1'b0;
        o_rgb <= shift_bits;
        phase <= 1'b1;
        if (col != col_last) o_rd_addr <= o_rd_addr + 1'b1;
      end
      if (do_phase_b) begin
        o_clk <= 1'b1;
        phase <= 1'b0;
        if (col != col_last) col <= col + 1'b1;
      end
      if (do_latch_1) begin
        o_oe      <= 1'b1;
        o_stb     <= 1'b1;
        o_row     <= row;
        lat_phase <= 1'b1;
      end
      if (do_latch_2) begin
        o_stb     <= 1'b0;
        lat_phase <= 1'b0;
        disp      <= disp_load;
        o_oe      <= (disp_load == '0);
        col       <= '0;
        o_rd_addr <= row_base;
        row       <= row_nxt;
        if (plane == plane_last) begin
          plane <= '0;
          if (row == row_last) o_frame_done <= 1'b1;
        end else begin
          plane <= plane + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hub75_bcm_scan.sv
// Directed bench for hub75_bcm_scan on a 4x4 panel, two segments, two bitplanes.
module tb_hub75_bcm_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_enable;
  logic [3:0]  i_clk_div;
  logic [7:0]  i_brightness;
  logic [3:0]  o_rd_addr;
  logic [11:0] i_rd_data;
  logic        o_clk;
  logic        o_stb;
  logic        o_oe;
  logic [0:0]  o_row;
  logic [5:0]  o_rgb;
  logic        o_frame_done;

  logic [11:0] mem [0:15];
  logic [11:0] rd_q;

  int errors = 0;
  int checks = 0;

  hub75_bcm_scan #(
    .hpixel_p   (4),
    .vpixel_p   (4),
    .bpp_p      (2),
    .segments_p (2),
    .lsb_time_p (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_enable     (i_enable),
    .i_clk_div    (i_clk_div),
    .i_brightness (i_brightness),
    .o_rd_addr    (o_rd_addr),
    .i_rd_data    (i_rd_data),
    .o_clk        (o_clk),
    .o_stb        (o_stb),
    .o_oe         (o_oe),
    .o_row        (o_row),
    .o_rgb        (o_rgb),
    .o_frame_done (o_frame_done)
  );

  always #5 clk = ~clk;

  // Synchronous frame buffer: data one clock after the address.
  always @(posedge clk) rd_q <= mem[o_rd_addr];
  assign i_rd_data = rd_q;

  // Panel-side observer, sampled on the falling edge.
  int         cyc = 0;
  int         oe_run = 0;
  int         oe_low_total = 0;
  int         fd_cnt = 0;
  logic       prev_clk = 1'b0;
  logic       prev_stb = 1'b0;
  int         oe_runs[$];
  int         rise_cyc[$];
  logic [5:0] rgb_q[$];
  int         stb_cyc[$];
  logic [0:0] stb_rows[$];

  always @(negedge clk) begin
    cyc      <= cyc + 1;
    prev_clk <= o_clk;
    prev_stb <= o_stb;
    if (o_clk === 1'b1 && prev_clk === 1'b0) begin
      rise_cyc.push_back(cyc);
      rgb_q.push_back(o_rgb);
    end
    if (o_stb === 1'b1 && prev_stb === 1'b0) begin
      stb_cyc.push_back(cyc);
      stb_rows.push_back(o_row);
    end
    if (o_oe === 1'b0) begin
      oe_run       <= oe_run + 1;
      oe_low_total <= oe_low_total + 1;
    end else if (oe_run > 0) begin
      oe_runs.push_back(oe_run);
      oe_run <= 0;
    end
    if (o_frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
  end

  function automatic int run_at(input int i);
    return (i < oe_runs.size()) ? oe_runs[i] : -1;
  endfunction
  function automatic int rise_at(input int i);
    return (i < rise_cyc.size()) ? rise_cyc[i] : -1000;
  endfunction
  function automatic int rgb_at(input int i);
    return (i < rgb_q.size()) ? int'(rgb_q[i]) : -1;
  endfunction
  function automatic int stbc_at(input int i);
    return (i < stb_cyc.size()) ? stb_cyc[i] : -1000;
  endfunction
  function automatic int row_at(input int i);
    return (i < stb_rows.size()) ? int'(stb_rows[i]) : -1;
  endfunction

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_stb(input int target, input int limit, input string tag);
    int n;
    n = 0;
    while (stb_cyc.size() < target && n < limit) begin
      step(1);
      n++;
    end
    chk(tag, 32'(stb_cyc.size() >= target), 32'd1);
  endtask

  task automatic wait_rise(input int target, input int limit, input string tag);
    int n;
    n = 0;
    while (rise_cyc.size() < target && n < limit) begin
      step(1);
      n++;
    end
    chk(tag, 32'(rise_cyc.size() >= target), 32'd1);
  endtask

  task automatic wait_fd(input int target, input int limit, input string tag);
    int n;
    n = 0;
    while (fd_cnt < target && n < limit) begin
      step(1);
      n++;
    end
    chk(tag, 32'(fd_cnt >= target), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_stb, s_runs, s_rise, s_fd, s_low;

    for (int a = 0; a < 16; a++) mem[a] = 12'h000;
    mem[6] = 12'h020;  // row 1, col 2, segment 0 R = 2'b10

    rst          = 1'b1;
    i_enable     = 1'b0;
    i_clk_div    = 4'd0;
    i_brightness = 8'd1;
    step(3);
    chk("rst_oe",   32'(o_oe), 1);
    chk("rst_clk",  32'(o_clk), 0);
    chk("rst_stb",  32'(o_stb), 0);
    chk("rst_row",  32'(o_row), 0);
    chk("rst_rgb",  32'(o_rgb), 0);
    chk("rst_addr", 32'(o_rd_addr), 0);
    chk("rst_fd",   32'(o_frame_done), 0);
    rst = 1'b0;
    step(2);
    chk("idle_oe", 32'(o_oe), 1);

    // One full frame at clk_div=0, brightness=1.
    i_enable = 1'b1;
    wait_fd(1, 400, "t1_frame_done_timeout");
    chk("t1_fd_high",    32'(o_frame_done), 1);
    chk("t1_addr_wrap",  32'(o_rd_addr), 0);
    chk("t1_stb_count",  32'(stb_cyc.size()), 4);
    chk("t1_clk_rises",  32'(rise_cyc.size()), 16);
    chk("t1_oe_p0_r0",   32'(run_at(0)), 1);
    chk("t1_oe_p1_r0",   32'(run_at(1)), 2);
    chk("t1_oe_p0_r1",   32'(run_at(2)), 1);
    step(1);
    chk("t1_fd_single",  32'(o_frame_done), 0);
    wait_stb(5, 100, "t1_next_latch_timeout");
    chk("t1_row_wrap",   32'(o_row), 0);
    chk("t1_fd_count",   32'(fd_cnt), 1);
    chk("t1_oe_p1_r1",   32'(run_at(3)), 2);
    chk("t1_stb_row0",   32'(row_at(0)), 0);
    chk("t1_stb_row1",   32'(row_at(1)), 0);
    chk("t1_stb_row2",   32'(row_at(2)), 1);
    chk("t1_stb_row3",   32'(row_at(3)), 1);
    chk("t1_stb_row4",   32'(row_at(4)), 0);
    for (int i = 0; i < 16; i++)
      chk($sformatf("t1_rgb_%0d", i), 32'(rgb_at(i)), (i == 14) ? 32'h4 : 32'h0);

    // Brightness 0: latches continue, panel never lit.
    i_enable = 1'b0;
    step(2);
    chk("t2_dis_oe", 32'(o_oe), 1);
    s_stb  = stb_cyc.size();
    s_fd   = fd_cnt;
    s_low  = oe_low_total;
    i_brightness = 8'd0;
    i_enable     = 1'b1;
    wait_fd(s_fd + 1, 400, "t2_frame_done_timeout");
    chk("t2_stb_count", 32'(stb_cyc.size() - s_stb), 4);
    chk("t2_oe_low",    32'(oe_low_total - s_low), 0);

    // clk_div=3, brightness=255: long display holds the following latch.
    i_enable = 1'b0;
    step(2);
    i_clk_div    = 4'd3;
    i_brightness = 8'd255;
    s_stb  = stb_cyc.size();
    s_rise = rise_cyc.size();
    s_runs = oe_runs.size();
    i_enable = 1'b1;
    wait_stb(s_stb + 3, 3000, "t3_latch_timeout");
    chk("t3_oclk_period", 32'(rise_at(s_rise + 1) - rise_at(s_rise)), 8);
    chk("t3_oe_p0",       32'(run_at(s_runs)), 255);
    chk("t3_oe_p1",       32'(run_at(s_runs + 1)), 510);
    chk("t3_latch_gap",   32'(stbc_at(s_stb + 2) - stbc_at(s_stb + 1)), 516);

    // Drop enable in the middle of row 1 plane 1 shift.
    i_enable = 1'b0;
    step(2);
    i_clk_div    = 4'd0;
    i_brightness = 8'd1;
    s_stb = stb_cyc.size();
    i_enable = 1'b1;
    wait_stb(s_stb + 3, 200, "t4_latch_timeout");
    s_rise = rise_cyc.size();
    wait_rise(s_rise + 2, 50, "t4_shift_timeout");
    chk("t4_pre_row", 32'(o_row), 1);
    i_enable = 1'b0;
    step(1);
    chk("t4_dis_oe",   32'(o_oe), 1);
    chk("t4_dis_clk",  32'(o_clk), 0);
    chk("t4_dis_stb",  32'(o_stb), 0);
    chk("t4_dis_row",  32'(o_row), 0);
    chk("t4_dis_addr", 32'(o_rd_addr), 0);

    // Re-enable, then async reset in the middle of the row 1 latch.
    s_stb  = stb_cyc.size();
    s_runs = oe_runs.size();
    i_enable = 1'b1;
    wait_stb(s_stb + 3, 200, "t5_latch_timeout");
    chk("t5_restart_row", 32'(row_at(s_stb)), 0);
    chk("t5_restart_p0",  32'(run_at(s_runs)), 1);
    chk("t5_restart_p1",  32'(run_at(s_runs + 1)), 2);
    chk("t5_mid_stb",     32'(o_stb), 1);
    chk("t5_mid_row",     32'(o_row), 1);
    rst = 1'b1;
    #1;
    chk("t5_arst_oe",   32'(o_oe), 1);
    chk("t5_arst_clk",  32'(o_clk), 0);
    chk("t5_arst_stb",  32'(o_stb), 0);
    chk("t5_arst_row",  32'(o_row), 0);
    chk("t5_arst_addr", 32'(o_rd_addr), 0);
    step(2);
    rst    = 1'b0;
    s_stb  = stb_cyc.size();
    s_rise = rise_cyc.size();
    wait_stb(s_stb + 4, 200, "t6_frame_timeout");
    chk("t6_row_first", 32'(row_at(s_stb)), 0);
    chk("t6_row_third", 32'(row_at(s_stb + 2)), 1);
    chk("t6_rgb_r0p0c2", 32'(rgb_at(s_rise + 2)), 0);
    chk("t6_rgb_r1p1c2", 32'(rgb_at(s_rise + 14)), 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
